bipolar_bitserial_sched: RTL
============================

// Module: bipolar_bitserial_sched
// PURPOSE
//  Bit-serial input scheduler for the crossbar wordline drivers. Accepts one vector of numLanes
//  two's-complement activations and splits it into positive/negative magnitudes via twos_to_bipolar.
//  Streams the P bit-planes, then the N bit-planes, LSB first, one plane per output handshake.
//  Sits between the activation buffer (upstream) and the wordline DAC/driver stage (downstream).
// PARAMETERS
//  inBits    8   max activation width; also max number of planes per phase
//  numLanes  32  activations per vector (one per wordline)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  asynchronous reset, active-high
//  input_bits   in   4                  active precision b; sampled on input accept
//  is_signed    in   1                  1: two's complement; 0: unsigned, no N phase; sampled on accept
//  in_valid     in   1                  upstream vector valid
//  in_ready     out  1                  scheduler can accept a vector
//  in_data      in   numLanes*inBits    activation vector, lane i at [i]
//  out_valid    out  1                  plane valid
//  out_ready    in   1                  driver accepts plane
//  out_plane    out  numLanes           bit k of every lane's magnitude for the current phase
//  out_neg      out  1                  0 = P phase, 1 = N phase
//  out_bit_idx  out  4                  plane index k (0 = LSB)
//  out_last     out  1                  final plane of this vector
//  busy         out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_plane=0, out_neg=0,
//    out_bit_idx=0, out_last=0, busy=0, magnitude/config registers cleared.
//  - Precision: b_eff = input_bits if 1..inBits; else (0 or >inBits) b_eff = inBits.
//    Lane bits at positions >= b_eff are ignored (masked) before conversion.
//  - Signed: sign = bit b_eff-1 of the lane; P = value if positive, N = -value (b_eff-bit
//    magnitude) if negative. -2^(b-1) gives N = 2^(b-1); it fits in b_eff bits and is not lost.
//    Zero gives P=N=0.
//  - Unsigned: P = masked value, N = 0.
//  - FSM: IDLE -> PPH -> NPH -> IDLE.
//    - IDLE: in_ready=1. On accept (in_valid & in_ready), register P/N, b_eff and skip_n, then go to PPH.
//      skip_n = !is_signed | (all N lanes == 0).
//    - PPH: out_valid=1, out_neg=0, out_plane[i]=P[i][k]. Advance k on out_valid&out_ready.
//      On k==b_eff-1 fire: go to NPH with k=0, or, if skip_n, to IDLE / PPH (see back-to-back).
//    - NPH: as PPH with out_neg=1, out_plane[i]=N[i][k]. On k==b_eff-1 fire: go to IDLE.
//  - out_last=1 on plane b_eff-1 of NPH, or of PPH when skip_n.
//  - Latency: vector accepted at edge T -> first plane valid after edge T (cycle T+1).
//  - Throughput: one plane per cycle while out_ready=1. Total planes per vector = b_eff*(skip_n?1:2).
//  - Back-to-back: in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
//    An accept on the last-plane fire goes directly to PPH with k=0, with no idle bubble.
//  - Stall: while out_valid & !out_ready, out_plane/out_neg/out_bit_idx/out_last hold stable.
//  - P phase is always emitted, even when all P lanes are zero (the phase boundary is kept for
//    downstream integration).
//  - input_bits/is_signed changes while busy: no effect until the next accept.
//  - rst mid-stream: the plane is dropped, all state returns to reset values immediately. No partial
//    vector resumes.
// STRUCTURE
//  - Shared package qr_acc_pkg holds:
//    - typedef enum logic [1:0] {S_IDLE, S_PPH, S_NPH} sched_state_t
//    - constant PHASE_P=1'b0, PHASE_N=1'b1
//  - Sub-module: one twos_to_bipolar #(inBits, numLanes) instance, input_bits driven by b_eff.
//    The unsigned bypass is muxed outside it.
//  - Bit-plane extraction: registered P/N magnitude arrays indexed by k. No shift registers needed.
// TESTING
//  1. Reset then idle: rst pulse -> all outputs at reset values, in_ready=1. Async assert
//     mid-cycle clears out_valid without a clock edge.
//  2. Signed b=4, lanes {3,-3,0,-8}, out_ready=1:
//     - 8 planes in order: P k0..3 = {1,0,0,0},{1,0,0,0},{0,0,0,0},{0,0,0,0}
//     - then N k0..3 = {0,1,0,0},{0,1,0,0},{0,0,0,0},{0,0,0,1}
//     - out_last on the 8th plane
//  3. Unsigned b=8, lanes all 0xA5: 8 P planes alternate lanes-all-1/0 per 0xA5 bits,
//     no N phase, out_last on k=7.
//  4. Signed, all lanes non-negative {5,1}: N skipped, 4 planes (b=4), out_last at P k=3.
//     input_bits=0 -> b_eff=inBits: 8 planes.
//  5. Back-to-back: in_valid held with two vectors, out_ready=1 -> second vector accepted on the
//     first vector's out_last cycle, no bubble.
//  6. Stall: random out_ready toggling -> outputs stable across stalls, plane sequence identical
//     to the out_ready=1 case. rst asserted during NPH -> IDLE, the next vector streams from P k0.

Source files
------------

// File: rtl/qr_acc_pkg.sv
// Shared types and helpers for the crossbar accelerator input path.
package qr_acc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PPH, S_NPH} sched_state_t;

  localparam logic PHASE_P = 1'b0;
  localparam logic PHASE_N = 1'b1;

  // Requested precision, clamped to 1..max_bits; 0 or out-of-range selects full width.
  function automatic logic [3:0] eff_bits(input logic [3:0] req, input int unsigned max_bits);
    if (req == 4'd0 || int'(req) > int'(max_bits)) begin
      return 4'(max_bits);
    end
    return req;
  endfunction

endpackage

// File: rtl/twos_to_bipolar.sv
// Masks each lane to the active precision and splits it into positive/negative magnitudes.
module twos_to_bipolar #(
  parameter int unsigned inBits   = 8,
  parameter int unsigned numLanes = 32
) (
  input  logic [numLanes*inBits-1:0] in_data,
  input  logic [3:0]                 input_bits,
  output logic [numLanes*inBits-1:0] masked,
  output logic [numLanes*inBits-1:0] p_mag,
  output logic [numLanes*inBits-1:0] n_mag
);

  // Per-lane mask, sign extraction and negation at the active precision.
  always_comb begin
    logic [inBits-1:0] mask;
    logic [inBits-1:0] sign_bit;
    logic [inBits-1:0] v;
    mask     = '0;
    sign_bit = '0;
    v        = '0;
    masked   = '0;
    p_mag    = '0;
    n_mag    = '0;
    for (int j = 0; j < int'(inBits); j++) begin
      mask[j] = (j < int'(input_bits));
    end
    // Only the top set bit of the mask survives: that is the sign position.
    sign_bit = mask ^ (mask >> 1);
    for (int i = 0; i < int'(numLanes); i++) begin
      v = in_data[i*inBits +: inBits] & mask;
      masked[i*inBits +: inBits] = v;
      if ((v & sign_bit) != '0) begin
        // Most-negative value negates to 2^(b-1), which still fits in b bits.
        n_mag[i*inBits +: inBits] = (~v + inBits'(1)) & mask;
      end else begin
        p_mag[i*inBits +: inBits] = v;
      end
    end
  end

endmodule

// File: rtl/bipolar_bitserial_sched.sv
// Bit-serial wordline scheduler: streams P then N bit-planes of one activation vector, LSB first.
module bipolar_bitserial_sched
  import qr_acc_pkg::*;
#(
  parameter int unsigned inBits   = 8,
  parameter int unsigned numLanes = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 input_bits,
  input  logic                       is_signed,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [numLanes*inBits-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [numLanes-1:0]        out_plane,
  output logic                       out_neg,
  output logic [3:0]                 out_bit_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned IdxW = (inBits > 1) ? $clog2(inBits) : 1;

  sched_state_t                      state_q, state_d;
  logic [3:0]                        k_q, k_d;
  logic [3:0]                        b_eff_q, b_eff_d;
  logic                              skip_n_q, skip_n_d;
  logic [numLanes-1:0][inBits-1:0]   p_q, p_d, n_q, n_d;

  logic [3:0]                        b_eff_in;
  logic [numLanes*inBits-1:0]        masked, p_conv, n_conv;
  logic [numLanes-1:0][inBits-1:0]   p_load, n_load;
  logic                              skip_n_in;
  logic                              k_end, fire, accept;

  assign b_eff_in = eff_bits(input_bits, inBits);

  twos_to_bipolar #(
    .inBits   (inBits),
    .numLanes (numLanes)
  ) u_conv (
    .in_data    (in_data),
    .input_bits (b_eff_in),
    .masked     (masked),
    .p_mag      (p_conv),
    .n_mag      (n_conv)
  );

  // Unsigned vectors bypass the converter: whole masked value is P, no N phase.
  always_comb begin
    p_load    = is_signed ? p_conv : masked;
    n_load    = is_signed ? n_conv : '0;
    skip_n_in = !is_signed || (n_conv == '0);
  end

  assign out_valid   = (state_q != S_IDLE);
  assign busy        = out_valid;
  assign out_neg     = (state_q == S_NPH) ? PHASE_N : PHASE_P;
  assign out_bit_idx = k_q;
  assign k_end       = (k_q == b_eff_q - 4'd1);
  assign out_last    = out_valid && k_end && ((state_q == S_NPH) || skip_n_q);
  assign fire        = out_valid && out_ready;
  assign in_ready    = (state_q == S_IDLE) || (fire && out_last);
  assign accept      = in_valid && in_ready;

  // Select bit k of every lane's magnitude for the current phase.
  always_comb begin
    out_plane = '0;
    for (int i = 0; i < int'(numLanes); i++) begin
      if (state_q == S_NPH) begin
        out_plane[i] = n_q[i][k_q[IdxW-1:0]];
      end else if (state_q == S_PPH) begin
        out_plane[i] = p_q[i][k_q[IdxW-1:0]];
      end
    end
  end

  // Phase sequencing; an accept on the final plane reloads straight into PPH.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    b_eff_d  = b_eff_q;
    skip_n_d = skip_n_q;
    p_d      = p_q;
    n_d      = n_q;
    if (fire) begin
      case (state_q)
        S_PPH: begin
          if (k_end) begin
            state_d = skip_n_q ? S_IDLE : S_NPH;
            k_d     = 4'd0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        S_NPH: begin
          if (k_end) begin
            state_d = S_IDLE;
            k_d     = 4'd0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
    if (accept) begin
      state_d  = S_PPH;
      k_d      = 4'd0;
      b_eff_d  = b_eff_in;
      skip_n_d = skip_n_in;
      p_d      = p_load;
      n_d      = n_load;
    end
  end

  // State and operand registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 4'd0;
      b_eff_q  <= 4'd0;
      skip_n_q <= 1'b0;
      p_q      <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      b_eff_q  <= b_eff_d;
      skip_n_q <= skip_n_d;
      p_q      <= p_d;
      n_q      <= n_d;
    end
  end

endmodule
